// File: rtl/iobuf_bank_reg.sv
// Bidirectional pad bank: owns/releases the pad bus with Hi-Z turnaround
// gaps, and synchronises the pad value back with a change-detect pulse.
module iobuf_bank_reg #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURNAROUND  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] IO,
  input  logic             drive_req,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             drive_ack,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_chg
);

  typedef enum logic [1:0] {IDLE, TURN_ON, DRIVE, TURN_OFF} state_t;

  localparam logic [3:0] TA    = 4'(TURNAROUND);
  localparam logic [2:0] BLANK = 3'(SYNC_STAGES + 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             oe;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [2:0]       blank;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (drive_req) begin
          if (TURNAROUND == 0) begin
            state_nxt = DRIVE;
          end else begin
            state_nxt = TURN_ON;
            cnt_nxt   = TA;
          end
        end
      end
      TURN_ON: begin
        if (!drive_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd1) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DRIVE: begin
        if (!drive_req) begin
          if (TURNAROUND == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = TURN_OFF;
            cnt_nxt   = TA;
          end
        end
      end
      TURN_OFF: begin
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output enable tracks the next state so the pad flips on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      oe      <= 1'b0;
      out_reg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      oe    <= (state_nxt == DRIVE);
      if (wr_en) out_reg <= wr_data;
    end
  end

  assign IO        = oe ? out_reg : 'z;
  assign drive_ack = oe;
  assign busy      = (state == TURN_ON) || (state == TURN_OFF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      blank  <= '0;
      rd_chg <= 1'b0;
    end else begin
      sync[0] <= IO;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      if (blank != BLANK) blank <= blank + 3'd1;
      // Pulse lands in the same cycle the new value appears on rd_data.
      rd_chg <= (blank == BLANK) && (sync[SYNC_STAGES-1] != sync[SYNC_STAGES-2]);
    end
  end

  assign rd_data = sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// Bench for iobuf_bank_reg: three instances (turnaround 2, 3, 0) sharing
// stimulus, checked every cycle against a phase/age reference model.
module tb_iobuf_bank_reg;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, drive_req, wr_en;
  logic [W-1:0] wr_data;
  logic         ext_en;
  logic [W-1:0] ext_val;

  logic [NI-1:0] ack, bsy, chg;
  logic [W-1:0]  rd [NI];
  tri0  [W-1:0]  pad0, pad1, pad2;

  assign pad0 = ext_en ? ext_val : 'z;

  iobuf_bank_reg #(.WIDTH(W), .TURNAROUND(2), .SYNC_STAGES(S)) u_t2 (
    .clk(clk), .reset_n(reset_n), .IO(pad0), .drive_req(drive_req), .wr_en(wr_en),
    .wr_data(wr_data), .drive_ack(ack[0]), .busy(bsy[0]), .rd_data(rd[0]), .rd_chg(chg[0]));
  iobuf_bank_reg #(.WIDTH(W), .TURNAROUND(3), .SYNC_STAGES(S)) u_t3 (
    .clk(clk), .reset_n(reset_n), .IO(pad1), .drive_req(drive_req), .wr_en(wr_en),
    .wr_data(wr_data), .drive_ack(ack[1]), .busy(bsy[1]), .rd_data(rd[1]), .rd_chg(chg[1]));
  iobuf_bank_reg #(.WIDTH(W), .TURNAROUND(0), .SYNC_STAGES(S)) u_t0 (
    .clk(clk), .reset_n(reset_n), .IO(pad2), .drive_req(drive_req), .wr_en(wr_en),
    .wr_data(wr_data), .drive_ack(ack[2]), .busy(bsy[2]), .rd_data(rd[2]), .rd_chg(chg[2]));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 receive, 1 gap before driving, 2 driving, 3 gap after.
  int           phase [NI];
  int           age   [NI];
  logic [W-1:0] out_m [NI];
  logic [W-1:0] hist  [NI][S];
  logic         chg_m [NI];
  int           since_rel;

  function automatic int ta(input int i);
    case (i)
      0: return 2;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] pad_of(input int i);
    case (i)
      0: return pad0;
      1: return pad1;
      default: return pad2;
    endcase
  endfunction

  function automatic logic [W-1:0] pad_model(input int i);
    if (phase[i] == 2) return out_m[i];
    if (i == 0 && ext_en) return ext_val;
    return '0;
  endfunction

  task automatic check(input string tag, input int idx, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    logic [W-1:0] pn [NI];
    @(posedge clk);
    for (int i = 0; i < NI; i++) pn[i] = pad_model(i);
    if (!reset_n) begin
      since_rel = 0;
      for (int i = 0; i < NI; i++) begin
        phase[i] = 0; age[i] = 0; out_m[i] = '0; chg_m[i] = 1'b0;
        for (int s = 0; s < S; s++) hist[i][s] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chg_m[i] = (since_rel >= S + 1) && (hist[i][S-1] != hist[i][S-2]);
        for (int s = S - 1; s > 0; s--) hist[i][s] = hist[i][s-1];
        hist[i][0] = pn[i];
        case (phase[i])
          0: if (drive_req) begin
               if (ta(i) == 0) phase[i] = 2;
               else begin phase[i] = 1; age[i] = 0; end
             end
          1: if (!drive_req) phase[i] = 0;
             else begin
               age[i]++;
               if (age[i] == ta(i)) phase[i] = 2;
             end
          2: if (!drive_req) begin
               if (ta(i) == 0) phase[i] = 0;
               else begin phase[i] = 3; age[i] = 0; end
             end
          default: begin
               age[i]++;
               if (age[i] == ta(i)) phase[i] = 0;
             end
        endcase
        if (wr_en) out_m[i] = wr_data;
      end
      if (since_rel < 1000) since_rel++;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check("drive_ack", i, W'(ack[i]), W'(phase[i] == 2));
      check("busy",      i, W'(bsy[i]), W'(phase[i] == 1 || phase[i] == 3));
      check("rd_data",   i, rd[i], hist[i][S-1]);
      check("rd_chg",    i, W'(chg[i]), W'(chg_m[i]));
      check("pad",       i, pad_of(i), pad_model(i));
    end
  endtask

  initial begin
    reset_n = 1'b0; drive_req = 1'b0; wr_en = 1'b0; wr_data = '0;
    ext_en = 1'b0; ext_val = '0; since_rel = 0;
    for (int i = 0; i < NI; i++) begin
      phase[i] = 0; age[i] = 0; out_m[i] = '0; chg_m[i] = 1'b0;
      for (int s = 0; s < S; s++) hist[i][s] = '0;
    end
    step(); step();

    // Ownership handshake with 0xA5, then drop and quick re-raise.
    reset_n = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0; drive_req = 1'b1;
    step();
    check("k_busy", 0, W'(bsy[0]), 8'd1);
    step();
    check("k1_busy", 0, W'(bsy[0]), 8'd1);
    step();
    check("k2_pad", 0, pad0, 8'hA5);
    check("k2_ack", 0, W'(ack[0]), 8'd1);
    step(); step();
    drive_req = 1'b0;
    step();
    check("m_busy", 0, W'(bsy[0]), 8'd1);
    drive_req = 1'b1;
    for (int n = 0; n < 8; n++) step();
    check("redrive_pad", 0, pad0, 8'hA5);

    // Single-cycle request: every instance with a gap must abort silently.
    drive_req = 1'b0;
    for (int n = 0; n < 8; n++) step();
    drive_req = 1'b1;
    step();
    drive_req = 1'b0;
    for (int n = 0; n < 4; n++) step();

    // Random traffic with the pad loop-back only.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) drive_req = ~drive_req;
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = W'($urandom);
      step();
    end

    // Let every instance settle back to receive, then drive the pad externally.
    drive_req = 1'b0; wr_en = 1'b0;
    for (int n = 0; n < 40 && (phase[0] != 0 || phase[1] != 0 || phase[2] != 0); n++) step();
    check("settled", 0, W'(phase[0] + phase[1] + phase[2]), 8'd0);
    step(); step(); step();
    ext_en = 1'b1; ext_val = 8'h3C;
    step(); step();
    check("ext_rd", 0, rd[0], 8'h3C);
    for (int n = 0; n < 4; n++) step();
    for (int n = 0; n < 6; n++) begin
      ext_val = W'($urandom);
      step(); step(); step();
    end
    ext_en = 1'b0;
    for (int n = 0; n < 4; n++) step();

    // Reset while driving 0xFF releases at once.
    wr_en = 1'b1; wr_data = 8'hFF; drive_req = 1'b1;
    step();
    wr_en = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("pre_rst_pad", 0, pad0, 8'hFF);
    reset_n = 1'b0;
    step();
    check("rst_ack", 0, W'(ack[0]), 8'd0);
    check("rst_pad", 0, pad0, 8'h00);
    reset_n = 1'b1; drive_req = 1'b0;
    for (int n = 0; n < 8; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
